// File: rtl/ctrl_pipe.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// ctrl_pipe
//   Carries the decode-stage control bundles (EX, M, WB) through the ID/EX,
//   EX/MEM and MEM/WB pipeline registers. Each stage's fields are presented as
//   named strobes. The block also detects data hazards and branch-taken flushes
//   and drives stall/flush back to fetch/decode.
//
//   Build option:
//     CTRL_PIPE_FORWARD_EN defined   : forward_a/forward_b select EX/MEM or
//                                      MEM/WB results, and only load-use stalls.
//     CTRL_PIPE_FORWARD_EN undefined : forward_* tied to 00, and any RAW against
//                                      ID/EX or EX/MEM stalls decode.
//
//   Ports
//     clk, rst          clock, synchronous active-high reset
//     id_valid          decode slot holds a real instruction
//     id_ex/id_m/id_wb  control bundles from decode
//     id_rs/id_rt/id_rd register specifiers of the decoding instruction
//     ex_zero           ALU zero flag of the instruction currently in EX
//     ex_*              EX-stage strobes and destination
//     mem_*, pc_src     MEM-stage strobes and branch-taken
//     wb_*              WB-stage strobes and destination
//     stall, flush      hazard controls back to fetch/decode
//     forward_a/b       EX operand select: 00 regfile, 10 EX/MEM, 01 MEM/WB
// -----------------------------------------------------------------------------
module ctrl_pipe #(
    parameter int REG_W = 5,
    parameter int EX_W  = 4,
    parameter int M_W   = 3,
    parameter int WB_W  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [EX_W-1:0]  id_ex,
    input  logic [M_W-1:0]   id_m,
    input  logic [WB_W-1:0]  id_wb,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic [REG_W-1:0] id_rd,
    input  logic             ex_zero,
    output logic             ex_reg_dst,
    output logic             ex_alu_src,
    output logic [1:0]       ex_alu_op,
    output logic [REG_W-1:0] ex_dest,
    output logic             mem_branch,
    output logic             mem_read,
    output logic             mem_write,
    output logic             pc_src,
    output logic             wb_reg_write,
    output logic             wb_mem_to_reg,
    output logic [REG_W-1:0] wb_dest,
    output logic             stall,
    output logic             flush,
    output logic [1:0]       forward_a,
    output logic [1:0]       forward_b
);

    // Bundle field positions
    localparam int EX_REG_DST    = 3;
    localparam int EX_ALU_OP_HI  = 2;
    localparam int EX_ALU_OP_LO  = 1;
    localparam int EX_ALU_SRC    = 0;
    localparam int M_BRANCH      = 2;
    localparam int M_MEM_READ    = 1;
    localparam int M_MEM_WRITE   = 0;
    localparam int WB_REG_WRITE  = 1;
    localparam int WB_MEM_TO_REG = 0;

    // ---------------------------------------------------------------- ID/EX
    logic [EX_W-1:0]  idex_ex_q,  idex_ex_d;
    logic [M_W-1:0]   idex_m_q,   idex_m_d;
    logic [WB_W-1:0]  idex_wb_q,  idex_wb_d;
    logic [REG_W-1:0] idex_rt_q,  idex_rt_d;
    logic [REG_W-1:0] idex_rd_q,  idex_rd_d;
`ifdef CTRL_PIPE_FORWARD_EN
    // Only the forwarding compare consumes the EX-stage rs.
    logic [REG_W-1:0] idex_rs_q,  idex_rs_d;
`endif

    // -------------------------------------------------------------- EX/MEM
    logic [M_W-1:0]   exmem_m_q,    exmem_m_d;
    logic [WB_W-1:0]  exmem_wb_q,   exmem_wb_d;
    logic [REG_W-1:0] exmem_dest_q, exmem_dest_d;
    logic             exmem_zero_q, exmem_zero_d;

    // -------------------------------------------------------------- MEM/WB
    logic [WB_W-1:0]  memwb_wb_q,   memwb_wb_d;
    logic [REG_W-1:0] memwb_dest_q, memwb_dest_d;

    logic             load_use;
    logic             raw_hazard;
    logic             idex_bubble;

    // A producer matches a consumer's source only when it writes, the source
    // is not r0, and the register numbers agree.
    function automatic logic src_hit(input logic [REG_W-1:0] src,
                                     input logic [REG_W-1:0] dst,
                                     input logic             wr);
        return wr && (src != '0) && (src == dst);
    endfunction

    // ------------------------------------------------------- stage strobes
    assign ex_reg_dst    = idex_ex_q[EX_REG_DST];
    assign ex_alu_src    = idex_ex_q[EX_ALU_SRC];
    assign ex_alu_op     = idex_ex_q[EX_ALU_OP_HI:EX_ALU_OP_LO];
    assign ex_dest       = idex_ex_q[EX_REG_DST] ? idex_rd_q : idex_rt_q;

    assign mem_branch    = exmem_m_q[M_BRANCH];
    assign mem_read      = exmem_m_q[M_MEM_READ];
    assign mem_write     = exmem_m_q[M_MEM_WRITE];
    assign pc_src        = exmem_m_q[M_BRANCH] & exmem_zero_q;

    assign wb_reg_write  = memwb_wb_q[WB_REG_WRITE];
    assign wb_mem_to_reg = memwb_wb_q[WB_MEM_TO_REG];
    assign wb_dest       = memwb_dest_q;

    // ------------------------------------------------------------- hazards
    // The load's result is not available until after MEM, so a consumer
    // directly behind it in decode must wait one cycle regardless of build.
    assign load_use = idex_m_q[M_MEM_READ] & id_valid &
                      (idex_rt_q != '0) &
                      ((idex_rt_q == id_rs) | (idex_rt_q == id_rt));

`ifdef CTRL_PIPE_FORWARD_EN
    assign raw_hazard = 1'b0;

    // EX/MEM holds the younger result, so it wins over MEM/WB.
    always_comb begin
        forward_a = 2'b00;
        forward_b = 2'b00;
        if (src_hit(idex_rs_q, exmem_dest_q, exmem_wb_q[WB_REG_WRITE]))
            forward_a = 2'b10;
        else if (src_hit(idex_rs_q, memwb_dest_q, memwb_wb_q[WB_REG_WRITE]))
            forward_a = 2'b01;
        if (src_hit(idex_rt_q, exmem_dest_q, exmem_wb_q[WB_REG_WRITE]))
            forward_b = 2'b10;
        else if (src_hit(idex_rt_q, memwb_dest_q, memwb_wb_q[WB_REG_WRITE]))
            forward_b = 2'b01;
    end
`else
    assign forward_a = 2'b00;
    assign forward_b = 2'b00;

    // Without forwarding, decode waits until the producer has left EX/MEM.
    // MEM/WB is not checked: the register file writes before it reads.
    assign raw_hazard = id_valid & (
        src_hit(id_rs, ex_dest,      idex_wb_q[WB_REG_WRITE])  |
        src_hit(id_rs, exmem_dest_q, exmem_wb_q[WB_REG_WRITE]) |
        src_hit(id_rt, ex_dest,      idex_wb_q[WB_REG_WRITE])  |
        src_hit(id_rt, exmem_dest_q, exmem_wb_q[WB_REG_WRITE]));
`endif

    // A taken branch squashes the stalled instruction anyway, so flush wins.
    assign flush = pc_src;
    assign stall = (load_use | raw_hazard) & ~flush;

    assign idex_bubble = ~id_valid | stall | flush;

    // ---------------------------------------------------------- next state
    always_comb begin
        idex_ex_d = id_ex;
        idex_m_d  = id_m;
        idex_wb_d = id_wb;
        idex_rt_d = id_rt;
        idex_rd_d = id_rd;
`ifdef CTRL_PIPE_FORWARD_EN
        idex_rs_d = id_rs;
`endif
        if (idex_bubble) begin
            idex_ex_d = '0;
            idex_m_d  = '0;
            idex_wb_d = '0;
            idex_rt_d = '0;
            idex_rd_d = '0;
`ifdef CTRL_PIPE_FORWARD_EN
            idex_rs_d = '0;
`endif
        end

        // The instruction in EX is on the wrong path when a branch in MEM
        // is taken.
        exmem_m_d    = idex_m_q;
        exmem_wb_d   = idex_wb_q;
        exmem_dest_d = ex_dest;
        exmem_zero_d = ex_zero;
        if (flush) begin
            exmem_m_d    = '0;
            exmem_wb_d   = '0;
            exmem_dest_d = '0;
            exmem_zero_d = 1'b0;
        end

        // The branch itself retires normally; its WB bundle is empty.
        memwb_wb_d   = exmem_wb_q;
        memwb_dest_d = exmem_dest_q;
    end

    // ------------------------------------------------------------ registers
    always_ff @(posedge clk) begin
        if (rst) begin
            idex_ex_q    <= '0;
            idex_m_q     <= '0;
            idex_wb_q    <= '0;
            idex_rt_q    <= '0;
            idex_rd_q    <= '0;
`ifdef CTRL_PIPE_FORWARD_EN
            idex_rs_q    <= '0;
`endif
            exmem_m_q    <= '0;
            exmem_wb_q   <= '0;
            exmem_dest_q <= '0;
            exmem_zero_q <= 1'b0;
            memwb_wb_q   <= '0;
            memwb_dest_q <= '0;
        end else begin
            idex_ex_q    <= idex_ex_d;
            idex_m_q     <= idex_m_d;
            idex_wb_q    <= idex_wb_d;
            idex_rt_q    <= idex_rt_d;
            idex_rd_q    <= idex_rd_d;
`ifdef CTRL_PIPE_FORWARD_EN
            idex_rs_q    <= idex_rs_d;
`endif
            exmem_m_q    <= exmem_m_d;
            exmem_wb_q   <= exmem_wb_d;
            exmem_dest_q <= exmem_dest_d;
            exmem_zero_q <= exmem_zero_d;
            memwb_wb_q   <= memwb_wb_d;
            memwb_dest_q <= memwb_dest_d;
        end
    end

endmodule
